wash_cycle_sequencer: RTL and testbench
=======================================

// Module: wash_cycle_sequencer
// PURPOSE
// Next-generation washing-machine cycle sequencer: one-hot FSM plus an internal phase timer.
// Adds compile-time phase durations, a run-time rinse count (multi-rinse loop), pause/resume
// with frozen timer, and a latched error code. Sits between the front-panel/sensor inputs
// and the valve, motor and door-lock drivers.
// PARAMETERS
// CNT_W       16  phase-counter width
// FILL_CYC     8  FILL duration, cycles (1..2^CNT_W-1; all durations likewise)
// WASH_CYC    20  WASH duration, cycles
// RINSE_CYC   12  RINSE duration, cycles
// DRAIN_CYC    8  DRAIN duration, cycles
// SPIN_CYC    16  SPIN duration, cycles
// MAX_RINSE    3  upper clamp on requested rinses
// RINSE_W      2  width of rinse_count/rinses_done; must hold MAX_RINSE
// PORTS
// clock               in   1        system clock, rising edge
// reset               in   1        asynchronous, active-low reset
// door_closed         in   1        door sensor, 1 = closed
// start_button        in   1        start / resume
// pause_button        in   1        pause running phase
// cancel_button       in   1        abort to IDLE
// rinse_count         in   RINSE_W  requested rinses, sampled on start
// motor_failure       in   1        fault
// low_water_pressure  in   1        fault
// sensor_malfunction  in   1        fault
// state               out  10       one-hot state
// phase_remaining     out  CNT_W    live phase counter
// rinses_done         out  RINSE_W  completed rinse passes
// error_code          out  3        0 none, 1 motor, 2 water, 3 sensor, 4 door
// complete            out  1        state==COMPLETE
// water_filling       out  1        state==FILL
// motor_on            out  1        state in {WASH,RINSE,SPIN}
// door_locked         out  1        state in {FILL,WASH,RINSE,DRAIN,SPIN,PAUSE}
// BEHAVIOUR
// - Reset (async, low): state=IDLE, counter=0, rinses_done=0, rinse target=0, error_code=0.
//   All decoded outputs 0 except state=IDLE. Reset mid-cycle aborts immediately.
// - States: IDLE, READY, FILL, WASH, RINSE, SPIN, DRAIN, COMPLETE, PAUSE, ERROR.
// - IDLE -> READY when door_closed. READY -> IDLE when !door_closed.
// - READY & start_button & door_closed -> FILL.
//   Latch target=min(rinse_count,MAX_RINSE). Clear rinses_done and the washed flag.
// - Phase entry loads counter=DUR-1. Counter decrements each cycle; leave the phase on the
//   cycle counter==0. Each phase therefore lasts exactly DUR cycles.
// - Sequence: FILL->WASH->DRAIN (sets washed). After DRAIN:
//   washed & rinses_done<target -> FILL. FILL with washed set -> RINSE. RINSE->DRAIN,
//   rinses_done++ on RINSE exit. Otherwise DRAIN->SPIN. SPIN->COMPLETE.
// - target=0: FILL,WASH,DRAIN,SPIN only.
// - COMPLETE -> IDLE when !door_closed.
// - PAUSE: pause_button in FILL/WASH/RINSE/DRAIN/SPIN -> PAUSE. Phase saved, counter frozen.
//   PAUSE & start_button -> saved phase, counter resumes from frozen value.
//   Pause with counter==0 in the same cycle: pause wins; on resume the phase exits
//   the next cycle.
// - Faults: any fault input high -> ERROR next cycle, from any state.
//   !door_closed while door_locked also -> ERROR, code 4.
//   error_code priority 1>2>3>4, latched on ERROR entry, held until IDLE.
// - ERROR exits only on cancel_button & all faults low & door_closed -> IDLE
//   (clears error_code).
// - cancel_button in any non-ERROR state -> IDLE next cycle. Clears counter and rinses_done.
// - Priority per cycle: fault > cancel > pause > start > phase/door transition.
// - Outputs are decoded combinationally from the registered state. No extra latency.
// STRUCTURE
// - Shared package wash_pkg: state one-hot localparams (10 b), error-code constants,
//   STATE_W=10.
// - Sub-module phase_timer: load/value/enable inputs, count and zero outputs.
//   Instantiated once; the FSM drives load on phase entry and enable=!PAUSE.
// TESTING
// - Nominal, rinse_count=2: close door, start -> FILL 8, WASH 20, DRAIN 8,
//   then (FILL 8, RINSE 12, DRAIN 8) x2, SPIN 16, COMPLETE. rinses_done=2.
// - rinse_count=3 with MAX_RINSE=3, then rinse_count=0 -> 3 rinse loops, then none.
//   Check each phase length exactly.
// - Pause in WASH at phase_remaining=5, wait 10 cycles -> state PAUSE, counter stays 5,
//   door_locked=1. Start -> WASH, exits 6 cycles later.
// - motor_failure and low_water_pressure both high in RINSE -> next cycle ERROR,
//   error_code=1. Cancel while fault high -> stays ERROR. Drop faults + cancel -> IDLE,
//   code 0.
// - Door opened during SPIN -> ERROR, code 4. Cancel and pause together in DRAIN ->
//   IDLE (cancel wins).
// - Assert reset low mid-FILL -> IDLE asynchronously, all outputs at reset values.
//   Release -> IDLE, waits for door.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine cycle sequencer: one-hot state
// codes, error codes and the fault-priority encoder.
package wash_pkg;

  localparam int STATE_W = 10;

  localparam logic [STATE_W-1:0] ST_IDLE     = 10'b00_0000_0001;
  localparam logic [STATE_W-1:0] ST_READY    = 10'b00_0000_0010;
  localparam logic [STATE_W-1:0] ST_FILL     = 10'b00_0000_0100;
  localparam logic [STATE_W-1:0] ST_WASH     = 10'b00_0000_1000;
  localparam logic [STATE_W-1:0] ST_RINSE    = 10'b00_0001_0000;
  localparam logic [STATE_W-1:0] ST_SPIN     = 10'b00_0010_0000;
  localparam logic [STATE_W-1:0] ST_DRAIN    = 10'b00_0100_0000;
  localparam logic [STATE_W-1:0] ST_COMPLETE = 10'b00_1000_0000;
  localparam logic [STATE_W-1:0] ST_PAUSE    = 10'b01_0000_0000;
  localparam logic [STATE_W-1:0] ST_ERROR    = 10'b10_0000_0000;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_MOTOR  = 3'd1;
  localparam logic [2:0] ERR_WATER  = 3'd2;
  localparam logic [2:0] ERR_SENSOR = 3'd3;
  localparam logic [2:0] ERR_DOOR   = 3'd4;

  // Highest-priority active fault wins when several are raised together.
  function automatic logic [2:0] fault_code(input logic motor, input logic water,
                                            input logic sensor, input logic door);
    if (motor)       return ERR_MOTOR;
    else if (water)  return ERR_WATER;
    else if (sensor) return ERR_SENSOR;
    else if (door)   return ERR_DOOR;
    else             return ERR_NONE;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counting phase timer: loads a duration, decrements while enabled and
// parks at zero.
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Washing-machine cycle sequencer: one-hot FSM driving fill/wash/rinse/drain/spin
// phases with a multi-rinse loop, pause/resume and a latched error code.
module wash_cycle_sequencer
  import wash_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int FILL_CYC  = 8,
  parameter int WASH_CYC  = 20,
  parameter int RINSE_CYC = 12,
  parameter int DRAIN_CYC = 8,
  parameter int SPIN_CYC  = 16,
  parameter int MAX_RINSE = 3,
  parameter int RINSE_W   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               door_closed,
  input  logic               start_button,
  input  logic               pause_button,
  input  logic               cancel_button,
  input  logic [RINSE_W-1:0] rinse_count,
  input  logic               motor_failure,
  input  logic               low_water_pressure,
  input  logic               sensor_malfunction,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   phase_remaining,
  output logic [RINSE_W-1:0] rinses_done,
  output logic [2:0]         error_code,
  output logic               complete,
  output logic               water_filling,
  output logic               motor_on,
  output logic               door_locked
);

  localparam logic [CNT_W-1:0]   FILL_LD  = CNT_W'(FILL_CYC - 1);
  localparam logic [CNT_W-1:0]   WASH_LD  = CNT_W'(WASH_CYC - 1);
  localparam logic [CNT_W-1:0]   RINSE_LD = CNT_W'(RINSE_CYC - 1);
  localparam logic [CNT_W-1:0]   DRAIN_LD = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0]   SPIN_LD  = CNT_W'(SPIN_CYC - 1);
  localparam logic [RINSE_W-1:0] MAX_R    = RINSE_W'(MAX_RINSE);

  logic [STATE_W-1:0] next_state;
  logic [STATE_W-1:0] saved_phase;
  logic [RINSE_W-1:0] target;
  logic [RINSE_W-1:0] rinse_req;
  logic               washed;
  logic               any_fault;
  logic               door_breach;
  logic               in_phase;
  logic               timer_load;
  logic [CNT_W-1:0]   timer_value;
  logic               timer_enable;
  logic [CNT_W-1:0]   timer_count;
  logic               timer_zero;

  assign any_fault   = motor_failure | low_water_pressure | sensor_malfunction;
  assign door_breach = !door_closed && door_locked;
  assign in_phase    = (state == ST_FILL) || (state == ST_WASH) || (state == ST_RINSE) ||
                       (state == ST_DRAIN) || (state == ST_SPIN);
  assign rinse_req   = (rinse_count > MAX_R) ? MAX_R : rinse_count;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (timer_load),
    .value  (timer_value),
    .enable (timer_enable),
    .count  (timer_count),
    .zero   (timer_zero)
  );

  assign phase_remaining = timer_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Priority: fault > cancel > pause > start > phase/door transition.
  always_comb begin
    next_state = state;
    if (any_fault || door_breach) begin
      next_state = ST_ERROR;
    end else if (state == ST_ERROR) begin
      if (cancel_button && door_closed) next_state = ST_IDLE;
    end else if (cancel_button) begin
      next_state = ST_IDLE;
    end else if (pause_button && in_phase) begin
      next_state = ST_PAUSE;
    end else begin
      case (state)
        ST_IDLE:     if (door_closed) next_state = ST_READY;
        ST_READY: begin
          if (start_button && door_closed) next_state = ST_FILL;
          else if (!door_closed)           next_state = ST_IDLE;
        end
        ST_FILL:     if (timer_zero) next_state = washed ? ST_RINSE : ST_WASH;
        ST_WASH:     if (timer_zero) next_state = ST_DRAIN;
        ST_RINSE:    if (timer_zero) next_state = ST_DRAIN;
        ST_DRAIN: begin
          if (timer_zero) next_state = (washed && (rinses_done < target)) ? ST_FILL : ST_SPIN;
        end
        ST_SPIN:     if (timer_zero) next_state = ST_COMPLETE;
        ST_COMPLETE: if (!door_closed) next_state = ST_IDLE;
        ST_PAUSE:    if (start_button) next_state = saved_phase;
        default:     next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    complete      = (state == ST_COMPLETE);
    water_filling = (state == ST_FILL);
    motor_on      = (state == ST_WASH) || (state == ST_RINSE) || (state == ST_SPIN);
    door_locked   = in_phase || (state == ST_PAUSE);
  end

  // A phase reloads only on fresh entry; resuming from PAUSE keeps the frozen count.
  always_comb begin
    timer_load   = 1'b0;
    timer_value  = '0;
    timer_enable = (state != ST_PAUSE) && (next_state != ST_PAUSE);
    if ((next_state != state) && (state != ST_PAUSE)) begin
      case (next_state)
        ST_FILL:  begin timer_load = 1'b1; timer_value = FILL_LD;  end
        ST_WASH:  begin timer_load = 1'b1; timer_value = WASH_LD;  end
        ST_RINSE: begin timer_load = 1'b1; timer_value = RINSE_LD; end
        ST_DRAIN: begin timer_load = 1'b1; timer_value = DRAIN_LD; end
        ST_SPIN:  begin timer_load = 1'b1; timer_value = SPIN_LD;  end
        default:  ;
      endcase
    end
    if ((next_state == ST_IDLE) && (state != ST_IDLE)) begin
      timer_load  = 1'b1;
      timer_value = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      saved_phase <= ST_IDLE;
      target      <= '0;
      washed      <= 1'b0;
      rinses_done <= '0;
      error_code  <= ERR_NONE;
    end else begin
      if ((next_state == ST_PAUSE) && (state != ST_PAUSE)) saved_phase <= state;
      if ((state == ST_READY) && (next_state == ST_FILL)) begin
        target      <= rinse_req;
        washed      <= 1'b0;
        rinses_done <= '0;
      end
      if ((state == ST_WASH) && (next_state == ST_DRAIN)) washed <= 1'b1;
      if ((state == ST_RINSE) && (next_state == ST_DRAIN)) rinses_done <= rinses_done + RINSE_W'(1);
      if ((state != ST_ERROR) && (next_state == ST_IDLE) && cancel_button) rinses_done <= '0;
      if ((state != ST_ERROR) && (next_state == ST_ERROR)) begin
        error_code <= fault_code(motor_failure, low_water_pressure, sensor_malfunction, door_breach);
      end else if ((state == ST_ERROR) && (next_state == ST_IDLE)) begin
        error_code <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Self-checking bench for wash_cycle_sequencer: phase schedules are predicted from
// the rinse target as a list of (phase, duration, rinses) and stepped cycle by cycle.
module tb_wash_cycle_sequencer;
  import wash_pkg::*;

  localparam int CNT_W     = 16;
  localparam int FILL_CYC  = 8;
  localparam int WASH_CYC  = 20;
  localparam int RINSE_CYC = 12;
  localparam int DRAIN_CYC = 8;
  localparam int SPIN_CYC  = 16;
  localparam int MAX_RINSE = 3;
  localparam int RINSE_W   = 2;

  localparam int P_FILL = 0, P_WASH = 1, P_RINSE = 2, P_DRAIN = 3, P_SPIN = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic door_closed = 1'b0, start_button = 1'b0, pause_button = 1'b0, cancel_button = 1'b0;
  logic motor_failure = 1'b0, low_water_pressure = 1'b0, sensor_malfunction = 1'b0;
  logic [RINSE_W-1:0] rinse_count = '0;
  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   phase_remaining;
  logic [RINSE_W-1:0] rinses_done;
  logic [2:0]         error_code;
  logic complete, water_filling, motor_on, door_locked;

  int tests = 0;
  int failed = 0;
  int cycles = 0;

  wash_cycle_sequencer #(
    .CNT_W(CNT_W), .FILL_CYC(FILL_CYC), .WASH_CYC(WASH_CYC), .RINSE_CYC(RINSE_CYC),
    .DRAIN_CYC(DRAIN_CYC), .SPIN_CYC(SPIN_CYC), .MAX_RINSE(MAX_RINSE), .RINSE_W(RINSE_W)
  ) dut (
    .clock(clock), .reset(reset), .door_closed(door_closed), .start_button(start_button),
    .pause_button(pause_button), .cancel_button(cancel_button), .rinse_count(rinse_count),
    .motor_failure(motor_failure), .low_water_pressure(low_water_pressure),
    .sensor_malfunction(sensor_malfunction), .state(state), .phase_remaining(phase_remaining),
    .rinses_done(rinses_done), .error_code(error_code), .complete(complete),
    .water_filling(water_filling), .motor_on(motor_on), .door_locked(door_locked)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cycles++;
    if (cycles > 20000) begin
      $display("FAIL cycle_budget observed=%0d required<=20000", cycles);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [STATE_W-1:0] ph_state(input int p);
    case (p)
      P_FILL:  return ST_FILL;
      P_WASH:  return ST_WASH;
      P_RINSE: return ST_RINSE;
      P_DRAIN: return ST_DRAIN;
      default: return ST_SPIN;
    endcase
  endfunction

  function automatic int ph_dur(input int p);
    case (p)
      P_FILL:  return FILL_CYC;
      P_WASH:  return WASH_CYC;
      P_RINSE: return RINSE_CYC;
      P_DRAIN: return DRAIN_CYC;
      default: return SPIN_CYC;
    endcase
  endfunction

  // Runs a full cycle from READY; optionally pauses phase pause_idx at step pause_k for hold cycles.
  task automatic run_cycle(input int rc, input int pause_idx, input int pause_k, input int hold);
    int ph_q[$];
    int rd_q[$];
    int tgt, d, k;
    logic [STATE_W-1:0] s;
    tgt = (rc > MAX_RINSE) ? MAX_RINSE : rc;
    ph_q = {P_FILL, P_WASH, P_DRAIN};
    rd_q = {0, 0, 0};
    for (int r = 1; r <= tgt; r++) begin
      ph_q.push_back(P_FILL);  rd_q.push_back(r - 1);
      ph_q.push_back(P_RINSE); rd_q.push_back(r - 1);
      ph_q.push_back(P_DRAIN); rd_q.push_back(r);
    end
    ph_q.push_back(P_SPIN); rd_q.push_back(tgt);
    chk("ready_before_start", state, ST_READY);
    rinse_count = RINSE_W'(rc);
    start_button = 1'b1;
    tick();
    start_button = 1'b0;
    for (int i = 0; i < ph_q.size(); i++) begin
      d = ph_dur(ph_q[i]);
      s = ph_state(ph_q[i]);
      k = 0;
      while (k < d) begin
        chk("phase_state", state, s);
        chk("phase_remaining", phase_remaining, d - 1 - k);
        chk("rinses_done", rinses_done, rd_q[i]);
        chk("phase_outputs", {water_filling, motor_on, door_locked, complete},
            {ph_q[i] == P_FILL, ph_q[i] inside {P_WASH, P_RINSE, P_SPIN}, 1'b1, 1'b0});
        if (i == pause_idx && k == pause_k) begin
          pause_button = 1'b1;
          tick();
          pause_button = 1'b0;
          for (int h = 0; h <= hold; h++) begin
            chk("pause_state", state, ST_PAUSE);
            chk("pause_frozen", phase_remaining, d - 1 - k);
            chk("pause_outputs", {motor_on, door_locked}, 2'b01);
            if (h < hold) tick();
          end
          start_button = 1'b1;
          tick();
          start_button = 1'b0;
          chk("resume_state", state, s);
          chk("resume_remaining", phase_remaining, d - 1 - k);
        end
        tick();
        k++;
      end
    end
    chk("complete_state", state, ST_COMPLETE);
    chk("complete_outputs", {complete, door_locked, motor_on}, 3'b100);
    chk("final_rinses", rinses_done, tgt);
    door_closed = 1'b0;
    tick();
    chk("complete_to_idle", state, ST_IDLE);
    door_closed = 1'b1;
    tick();
    chk("idle_to_ready", state, ST_READY);
  endtask

  initial begin
    int rc, len, idx;
    // Reset state
    #12;
    chk("reset_state", state, ST_IDLE);
    chk("reset_remaining", phase_remaining, 0);
    chk("reset_rinses", rinses_done, 0);
    chk("reset_error", error_code, 0);
    chk("reset_outputs", {complete, water_filling, motor_on, door_locked}, 4'b0000);
    reset = 1'b1;
    tick();
    chk("idle_waits_door", state, ST_IDLE);
    door_closed = 1'b1;
    tick();
    chk("door_to_ready", state, ST_READY);

    // Nominal schedules: 2, 3 and 0 rinses
    run_cycle(2, -1, 0, 0);
    run_cycle(3, -1, 0, 0);
    run_cycle(0, -1, 0, 0);
    // Pause in WASH at remaining 5, hold 10 cycles
    run_cycle(1, 1, WASH_CYC - 1 - 5, 10);
    // Pause on the cycle the RINSE counter reaches zero
    run_cycle(1, 4, RINSE_CYC - 1, 3);
    // Randomized rinse counts and pause points
    repeat (5) begin
      rc  = $urandom_range(0, 3);
      len = 4 + 3 * rc;
      idx = $urandom_range(0, len - 1);
      run_cycle(rc, idx, $urandom_range(0, FILL_CYC - 1), $urandom_range(0, 6));
    end

    // Motor + water fault in RINSE
    rinse_count = 2'd1;
    start_button = 1'b1;
    tick();
    start_button = 1'b0;
    advance(FILL_CYC + WASH_CYC + DRAIN_CYC + FILL_CYC);
    chk("reach_rinse", state, ST_RINSE);
    motor_failure = 1'b1;
    low_water_pressure = 1'b1;
    tick();
    chk("fault_error_state", state, ST_ERROR);
    chk("fault_code_motor", error_code, 1);
    chk("error_outputs", {motor_on, door_locked}, 2'b00);
    cancel_button = 1'b1;
    tick();
    chk("cancel_with_fault", state, ST_ERROR);
    chk("code_held", error_code, 1);
    motor_failure = 1'b0;
    low_water_pressure = 1'b0;
    tick();
    chk("error_cleared_state", state, ST_IDLE);
    chk("error_cleared_code", error_code, 0);
    cancel_button = 1'b0;
    tick();
    chk("ready_after_error", state, ST_READY);

    // Water + sensor fault from READY, exit blocked while door is open
    low_water_pressure = 1'b1;
    sensor_malfunction = 1'b1;
    tick();
    chk("fault_code_water", error_code, 2);
    low_water_pressure = 1'b0;
    sensor_malfunction = 1'b0;
    door_closed = 1'b0;
    cancel_button = 1'b1;
    tick();
    chk("error_needs_door", state, ST_ERROR);
    chk("error_door_open_code", error_code, 2);
    door_closed = 1'b1;
    tick();
    chk("error_exit", state, ST_IDLE);
    cancel_button = 1'b0;
    tick();
    chk("ready_again", state, ST_READY);

    // Door opened during SPIN
    rinse_count = 2'd0;
    start_button = 1'b1;
    tick();
    start_button = 1'b0;
    advance(FILL_CYC + WASH_CYC + DRAIN_CYC);
    chk("reach_spin", state, ST_SPIN);
    advance(3);
    door_closed = 1'b0;
    tick();
    chk("door_error_state", state, ST_ERROR);
    chk("door_error_code", error_code, 4);
    door_closed = 1'b1;
    cancel_button = 1'b1;
    tick();
    chk("door_error_exit", state, ST_IDLE);
    chk("door_error_cleared", error_code, 0);
    cancel_button = 1'b0;
    tick();

    // Cancel and pause together in the post-rinse DRAIN
    rinse_count = 2'd1;
    start_button = 1'b1;
    tick();
    start_button = 1'b0;
    advance(FILL_CYC + WASH_CYC + DRAIN_CYC + FILL_CYC + RINSE_CYC);
    chk("reach_drain", state, ST_DRAIN);
    chk("drain_rinses", rinses_done, 1);
    advance(2);
    cancel_button = 1'b1;
    pause_button = 1'b1;
    tick();
    cancel_button = 1'b0;
    pause_button = 1'b0;
    chk("cancel_wins", state, ST_IDLE);
    chk("cancel_clears_counter", phase_remaining, 0);
    chk("cancel_clears_rinses", rinses_done, 0);
    tick();
    chk("ready_after_cancel", state, ST_READY);

    // Asynchronous reset mid-FILL
    rinse_count = 2'd2;
    start_button = 1'b1;
    tick();
    start_button = 1'b0;
    advance(3);
    chk("mid_fill", phase_remaining, FILL_CYC - 1 - 3);
    reset = 1'b0;
    #1;
    chk("async_reset_state", state, ST_IDLE);
    chk("async_reset_remaining", phase_remaining, 0);
    chk("async_reset_outputs", {complete, water_filling, motor_on, door_locked, rinses_done, error_code}, 0);
    door_closed = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_idle", state, ST_IDLE);
    tick();
    chk("idle_holds", state, ST_IDLE);
    door_closed = 1'b1;
    tick();
    chk("post_reset_ready", state, ST_READY);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
